// File: rtl/alu_seq_if.sv
// alu_seq_if: start/operand/result bundle between a requester and the sequential ALU
interface alu_seq_if #(parameter int WIDTH = 4);
  logic                 init;
  logic [WIDTH-1:0]     portA;
  logic [WIDTH-1:0]     portB;
  logic [1:0]           opcode;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     remainder;
  logic                 busy;
  logic                 done;
  logic                 div_zero;
  modport master (output init, portA, portB, opcode,
                  input  result, remainder, busy, done, div_zero);
  modport slave  (input  init, portA, portB, opcode,
                  output result, remainder, busy, done, div_zero);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU; add/sub in one step, shift-add mul and restoring div in WIDTH steps
module alu_seq #(parameter int WIDTH = 4) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [2*W-1:0] x_q, x_d, acc_q, acc_d, res_q, res_d;
  logic [W-1:0]   y_q, y_d, rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dz_q, dz_d;
  logic [W:0]     sum, dif, trial, part;
  logic           qbit, dz_hit, fin;
  // x holds the shifting multiplicand (mul) or dividend/quotient (div); y the multiplier or divisor
  always_comb begin
    sum     = {1'b0, x_q[W-1:0]} + {1'b0, y_q};
    dif     = {1'b0, x_q[W-1:0]} - {1'b0, y_q};
    trial   = {acc_q[W-1:0], x_q[W-1]};
    qbit    = trial >= {1'b0, y_q};
    part    = qbit ? trial - {1'b0, y_q} : trial;
    dz_hit  = op_q == 2'b11 && y_q == '0;
    fin     = !op_q[1] || dz_hit || cnt_q == CW'(W - 1);
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    res_d   = res_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (bus.init) begin
        state_d = EXEC;
        op_d    = bus.opcode;
        x_d     = {{W{1'b0}}, bus.portA};
        y_d     = bus.portB;
        acc_d   = '0;
        cnt_d   = '0;
        dz_d    = 1'b0;
      end
      EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == 2'b10) begin
          acc_d = acc_q + (y_q[0] ? x_q : '0);
          x_d   = x_q << 1;
          y_d   = y_q >> 1;
        end else if (op_q == 2'b11) begin
          acc_d = {{(W-1){1'b0}}, part};
          x_d   = {x_q[2*W-2:0], qbit};
        end
        if (fin) begin
          state_d = DONE;
          res_d   = op_q == 2'b00 ? {{(W-1){1'b0}}, sum} :
                    op_q == 2'b01 ? {{(W-1){dif[W]}}, dif} :
                    op_q == 2'b10 ? acc_d :
                    dz_hit        ? {{W{1'b0}}, {W{1'b1}}} : {{W{1'b0}}, x_d[W-1:0]};
          rem_d   = op_q != 2'b11 ? '0 : dz_hit ? x_q[W-1:0] : part[W-1:0];
          dz_d    = dz_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end
  assign bus.result    = res_q;
  assign bus.remainder = rem_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  assign bus.div_zero  = dz_q;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 init  input  1  start request; sampled only in IDLE.
REQ-005 portA  input  WIDTH  operand A, unsigned.
REQ-006 portB  input  WIDTH  operand B, unsigned.
REQ-007 opcode  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 result  output  2*WIDTH  registered result; held until the next accepted start.
REQ-009 remainder  output  WIDTH  registered division remainder; 0 for non-div ops.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse marking result/remainder/div_zero valid.
REQ-012 div_zero  output  1  set with done when a div had portB = 0; cleared at the next accepted start.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-014 IDLE: init=1 at edge k SHALL capture portA, portB, opcode into internal registers, clear div_zero, and enter EXEC; init=0 stays IDLE.
REQ-015 Operands SHALL come only from the captured registers; input changes after edge k SHALL NOT affect the operation.
REQ-016 init in EXEC or DONE SHALL be ignored; it is not queued.
REQ-017 add: result = zero-extended portA + portB, carry in bit WIDTH; written at edge k+1.
REQ-018 sub: result[WIDTH:0] = ({0,A} - {0,B}) mod 2^(WIDTH+1); bits above WIDTH replicate bit WIDTH (two's-complement sign extension); written at edge k+1.
REQ-019 mul: shift-add, one partial-product step per cycle, WIDTH steps on edges k+1..k+WIDTH; full 2*WIDTH-bit product written at edge k+WIDTH.
REQ-020 div: restoring division, one quotient bit per cycle, MSB first, WIDTH steps on edges k+1..k+WIDTH; quotient in result[WIDTH-1:0], upper bits 0, remainder on remainder; written at edge k+WIDTH.
REQ-021 div with captured B = 0: no iterations; at edge k+1 result = {WIDTH zeros, WIDTH ones}, remainder = A, div_zero = 1.
REQ-022 An iteration counter SHALL count WIDTH steps; it SHALL NOT wrap or run past WIDTH.
REQ-023 On the edge completing EXEC the FSM SHALL enter DONE; done = 1 for exactly that one cycle, then IDLE on the next edge.
REQ-024 Latency init-edge to done-high cycle: 1 cycle (add, sub, div-by-zero); WIDTH cycles (mul, div).
REQ-025 result and remainder SHALL NOT change outside the completing edge or reset; intermediate values SHALL be kept in internal registers.
REQ-026 Unused opcode states SHALL NOT exist; all four codes are defined.

Reset
REQ-027 rst=1 SHALL immediately, without clock, force IDLE, result=0, remainder=0, busy=0, done=0, div_zero=0, counter and internal registers cleared.
REQ-028 rst asserted mid-EXEC SHALL abort the operation; no done pulse SHALL follow after rst release.
REQ-029 After rst deasserts, the first rising edge with init=1 SHALL be accepted normally.

Verification (WIDTH=4)
REQ-030 add A=15, B=15, init pulse at edge k -> result=0x1E, done high in the cycle after edge k+1, busy low afterwards.
REQ-031 sub A=2, B=5 -> result=0xFD at edge k+1; sub A=5, B=2 -> result=0x03.
REQ-032 mul A=15, B=15 -> result=0xE1, remainder=0, done exactly one cycle after edge k+4; inputs changed at k+1 do not alter result.
REQ-033 div A=13, B=4 -> result=0x03, remainder=1, div_zero=0 at edge k+4; div A=9, B=0 -> result=0x0F, remainder=9, div_zero=1 at edge k+1.
REQ-034 mul A=7, B=3 started, rst pulsed between edges k+2 and k+3 -> all outputs 0 at once, no done; then add A=1, B=1 -> result=0x02.
REQ-035 init held high across a full mul -> exactly one operation per IDLE visit; second start accepted at the edge after DONE.
